output_writeback: RTL



---
 rtl/output_writeback_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/output_writeback.sv | 108 ++++++++++
 3 files changed

// File: rtl/output_writeback_pkg.sv
// Shared types for the output write-back buffer: FSM state and buffered result entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package output_writeback_pkg;

   // Native result word width; the top's DATA_WIDTH is cast onto this field.
   localparam int WB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } wb_state_t;

   typedef struct packed {
      logic [WB_DATA_WIDTH-1:0] data;
      logic [31:0]              x;
      logic [31:0]              y;
      logic [31:0]              ch;
   } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with a registered head word.
// Latency: a push at edge N is visible on rdata/!empty after edge N.
// Backpressure: caller must never push when full without a pop, nor pop when empty.
// Ports: clk, arst_in (async, active high), push/pop strobes, wdata in, rdata head out,
//        full/empty/count status, all derived from registers.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     arst_in,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [AW:0]      count_n;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   always_comb begin
      rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
      count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // The head register is preloaded with whatever will sit at the read pointer after
   // this edge; a push into an otherwise-empty queue bypasses the memory. When the
   // queue goes empty the head simply keeps the last word handed out.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         if (count_n != '0) begin
            rdata <= (push && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
         end
      end
   end

endmodule

// File: rtl/output_writeback.sv
// Captures controller results with (x,y,ch) into a FIFO and streams them out over valid/ready.
// Latency: 1 cycle from in_valid pulse to out_valid/out_*; no combinational in->out path.
// Backpressure: controller cannot stall; almost_full warns early, a push into a full FIFO is dropped and flagged.
// Ports: clk, arst_in; start; in_valid/in_data/in_x/in_y/in_ch from controller;
//        out_valid/out_ready/out_data/out_x/out_y/out_ch to consumer;
//        status fill_level, almost_full, overflow, protocol_err, all_done.
module output_writeback
   import output_writeback_pkg::*;
#(
   parameter int DATA_WIDTH         = WB_DATA_WIDTH,
   parameter int FIFO_DEPTH         = 8,
   parameter int AF_MARGIN          = 2,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64
) (
   input  logic                          clk,
   input  logic                          arst_in,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [31:0]                   in_x,
   input  logic [31:0]                   in_y,
   input  logic [31:0]                   in_ch,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [31:0]                   out_x,
   output logic [31:0]                   out_y,
   output logic [31:0]                   out_ch,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          almost_full,
   output logic                          overflow,
   output logic                          protocol_err,
   output logic                          all_done
);

   wb_state_t state;
   wb_entry_t wr_entry;
   wb_entry_t rd_entry;
   logic      fifo_full;
   logic      fifo_empty;
   logic      accepting;
   logic      is_last;
   logic      push;
   logic      pop;

   assign accepting = (state == STREAM) || (state == DRAIN);
   assign is_last   = (in_x  == 32'(FEATURE_MAP_WIDTH  - 1)) &&
                      (in_y  == 32'(FEATURE_MAP_HEIGHT - 1)) &&
                      (in_ch == 32'(OUTPUT_NB_CHANNELS - 1));
   assign pop       = !fifo_empty && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push      = in_valid && accepting && (!fifo_full || pop);

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = WB_DATA_WIDTH'(in_data);
      wr_entry.x    = in_x;
      wr_entry.y    = in_y;
      wr_entry.ch   = in_ch;
   end

   sync_fifo #(
      .WIDTH ($bits(wb_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .arst_in (arst_in),
      .push    (push),
      .pop     (pop),
      .wdata   (wr_entry),
      .rdata   (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fill_level)
   );

   assign out_valid   = !fifo_empty;
   assign out_data    = DATA_WIDTH'(rd_entry.data);
   assign out_x       = rd_entry.x;
   assign out_y       = rd_entry.y;
   assign out_ch      = rd_entry.ch;
   assign almost_full = (FIFO_DEPTH - int'(fill_level)) <= AF_MARGIN;
   assign all_done    = (state == DONE);

   // Sticky flags: start clears them, but an error in the same cycle wins.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state        <= IDLE;
         overflow     <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         overflow     <= (overflow && !start) ||
                         (in_valid && accepting && fifo_full && !pop);
         protocol_err <= (protocol_err && !start) || (in_valid && !accepting);
         case (state)
            IDLE:    if (start) state <= STREAM;
            STREAM:  if (push && is_last) state <= DRAIN;
            // Empty with nothing arriving: the last result has been consumed.
            DRAIN:   if (fifo_empty && !push) state <= DONE;
            DONE:    if (start) state <= STREAM;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
